instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 114 +++++++++++
 tb/tb_instr_fetch_queue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-based prefetch into a small FIFO,
// with redirect flush and draining of stale in-flight responses.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr_data,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  typedef enum logic {S_FETCH, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_outst, r_stale, r_occ;
  logic [CW-1:0]   w_outst_nxt, w_stale_nxt;
  logic [AW-1:0]   r_head, r_tail;
  logic [31:0]     r_q_pc   [DEPTH];
  logic [31:0]     r_q_data [DEPTH];
  logic            w_req_hs, w_rsp, w_push, w_pop;
  logic [CW:0]     w_credit;
  logic [31:0]     w_rsp_pc, w_redir_pc;

  assign w_credit   = {1'b0, r_occ} + {1'b0, r_outst};
  assign mem_req_valid = rst_n && (r_state == S_FETCH)
                      && (w_credit < LIM);
  assign mem_req_addr  = r_fetch_pc;

  assign w_req_hs   = mem_req_valid && mem_req_ready;
  assign w_rsp      = mem_rsp_valid && (r_outst != '0);
  assign w_pop      = instr_valid && instr_ready;
  assign w_push     = w_rsp && (r_state == S_FETCH) && !redirect_valid;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // Requests are sequential, so the oldest live one sits r_outst words back
  assign w_rsp_pc = r_fetch_pc
                  - {{(30-CW){1'b0}}, r_outst, 2'b00};

  assign instr_valid = (r_occ != '0);
  assign instr_data  = instr_valid ? r_q_data[r_head] : '0;
  assign instr_pc    = instr_valid ? r_q_pc[r_head]   : '0;
  assign occupancy   = r_occ;

  always_comb begin
    w_outst_nxt = r_outst + CW'(w_req_hs) - CW'(w_rsp);
    w_stale_nxt = r_stale;
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_stale_nxt = w_outst_nxt;
      w_state_nxt = (w_outst_nxt != '0) ? S_DRAIN : S_FETCH;
    end else if (r_state == S_DRAIN) begin
      if (w_rsp)
        w_stale_nxt = r_stale - CW'(1);
      if (w_stale_nxt == '0)
        w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_stale    <= '0;
      r_occ      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stale <= w_stale_nxt;
      r_outst <= w_outst_nxt;
      if (redirect_valid)
        r_fetch_pc <= w_redir_pc;
      else if (w_req_hs)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      if (redirect_valid) begin
        r_occ  <= '0;
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push)
          r_tail <= r_tail + AW'(1);
        if (w_pop)
          r_head <= r_head + AW'(1);
        r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible through r_occ
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= w_rsp_pc;
      r_q_data[r_tail] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a 1-cycle memory model
// and logs of request and decoder handshakes.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  occupancy;

  logic        rsp_en = 1'b0;
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;
  int          rb = 0;
  int          pb = 0;
  logic [31:0] pend[$];
  logic [31:0] req_q[$];
  int          req_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_dat[$];
  int          pop_cyc[$];

  instr_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Memory returns ~addr, one beat per accepted request, in order
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      pend.delete();
      mem_rsp_valid <= 1'b0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back(mem_req_addr);
        req_q.push_back(mem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (instr_valid && instr_ready) begin
        pop_pc.push_back(instr_pc);
        pop_dat.push_back(instr_data);
        pop_cyc.push_back(cyc);
      end
      if (rsp_en && pend.size() > 0) begin
        mem_rsp_data  <= ~pend.pop_front();
        mem_rsp_valid <= 1'b1;
      end else begin
        mem_rsp_valid <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] get_req(int i);
    if (rb + i < req_q.size()) return req_q[rb+i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] get_ppc(int i);
    if (pb + i < pop_pc.size()) return pop_pc[pb+i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] get_pdat(int i);
    if (pb + i < pop_dat.size()) return pop_dat[pb+i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic int get_pcyc(int i);
    if (pb + i < pop_cyc.size()) return pop_cyc[pb+i];
    return -1000;
  endfunction

  function automatic int get_rcyc(int i);
    if (rb + i < req_cyc.size()) return req_cyc[rb+i];
    return -1000;
  endfunction

  task automatic mark();
    rb = req_q.size();
    pb = pop_pc.size();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    mem_req_ready  = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    rsp_en         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if (mem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_req_valid: got %b want 0", mem_req_valid);
    end
    nchk++;
    if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin
      nerr++;
      $display("FAIL rst_q: valid %b occ %0d want 0/0",
               instr_valid, occupancy);
    end
    nchk++;
    if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin
      nerr++;
      $display("FAIL rst_head: data %h pc %h want 0/0",
               instr_data, instr_pc);
    end
    do_reset();
    #1;
    nchk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      nerr++;
      $display("FAIL rst_release: valid %b addr %h want 1/0",
               mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    mark();
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    rsp_en        = 1'b1;
    repeat (12) @(negedge clk);
    nchk++;
    if (occupancy !== 3'd1) begin
      nerr++;
      $display("FAIL stream_occ: got %0d want 1", occupancy);
    end
    nchk++;
    if (get_pcyc(0) - get_rcyc(0) != 2) begin
      nerr++;
      $display("FAIL stream_latency: got %0d want 2",
               get_pcyc(0) - get_rcyc(0));
    end
    for (int i = 0; i < 6; i++) begin
      nchk++;
      if (get_req(i) !== 32'(4*i)) begin
        nerr++;
        $display("FAIL stream_req%0d: got %h want %h",
                 i, get_req(i), 32'(4*i));
      end
      nchk++;
      if (get_ppc(i) !== 32'(4*i) || get_pdat(i) !== ~32'(4*i)) begin
        nerr++;
        $display("FAIL stream_pop%0d: pc %h data %h want %h",
                 i, get_ppc(i), get_pdat(i), 32'(4*i));
      end
      nchk++;
      if (get_pcyc(i) != get_pcyc(0) + i) begin
        nerr++;
        $display("FAIL stream_rate%0d: cyc %0d want %0d",
                 i, get_pcyc(i), get_pcyc(0) + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mark();
    mem_req_ready = 1'b1;
    rsp_en        = 1'b1;
    repeat (8) @(negedge clk);
    nchk++;
    if (req_q.size() - rb != 4) begin
      nerr++;
      $display("FAIL bp_count: got %0d want 4", req_q.size() - rb);
    end
    nchk++;
    if (occupancy !== 3'd4 || mem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_full: occ %0d valid %b want 4/0",
               occupancy, mem_req_valid);
    end
    nchk++;
    if (instr_pc !== 32'h0 || instr_data !== ~32'h0) begin
      nerr++;
      $display("FAIL bp_hold: pc %h data %h want 0/ffffffff",
               instr_pc, instr_data);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    nchk++;
    if (occupancy !== 3'd3 || mem_req_valid !== 1'b1
        || mem_req_addr !== 32'h10) begin
      nerr++;
      $display("FAIL bp_pop: occ %0d valid %b addr %h want 3/1/10",
               occupancy, mem_req_valid, mem_req_addr);
    end
    repeat (4) @(negedge clk);
    nchk++;
    if (req_q.size() - rb != 5 || get_req(4) !== 32'h10) begin
      nerr++;
      $display("FAIL bp_refill: n %0d last %h want 5/10",
               req_q.size() - rb, get_req(4));
    end
    nchk++;
    if (occupancy !== 3'd4 || instr_pc !== 32'h4
        || instr_data !== ~32'h4 || mem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_head: occ %0d pc %h valid %b want 4/4/0",
               occupancy, instr_pc, mem_req_valid);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    mark();
    mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_req_ready = 1'b0;
    nchk++;
    if (req_q.size() - rb != 3) begin
      nerr++;
      $display("FAIL drain_out: got %0d want 3", req_q.size() - rb);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    rsp_en         = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    nchk++;
    if (instr_valid !== 1'b0 || occupancy !== 3'd0
        || mem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL drain_flush: valid %b occ %0d req %b want 0/0/0",
               instr_valid, occupancy, mem_req_valid);
    end
    mark();
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      nchk++;
      if (mem_req_valid !== 1'b0) begin
        nerr++;
        $display("FAIL drain_hold: got %b want 0", mem_req_valid);
      end
    end
    @(negedge clk);
    nchk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin
      nerr++;
      $display("FAIL drain_resume: valid %b addr %h want 1/1000",
               mem_req_valid, mem_req_addr);
    end
    repeat (5) @(negedge clk);
    nchk++;
    if (get_req(0) !== 32'h1000 || get_ppc(0) !== 32'h1000
        || get_pdat(0) !== ~32'h1000) begin
      nerr++;
      $display("FAIL drain_first: req %h pc %h data %h want 1000",
               get_req(0), get_ppc(0), get_pdat(0));
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    mark();
    mem_req_ready = 1'b1;
    rsp_en        = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    instr_ready    = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    nchk++;
    if (instr_valid !== 1'b0 || occupancy !== 3'd0
        || mem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL coin_flush: valid %b occ %0d req %b want 0/0/0",
               instr_valid, occupancy, mem_req_valid);
    end
    repeat (6) @(negedge clk);
    nchk++;
    if (get_req(0) !== 32'h0 || get_req(1) !== 32'h4
        || get_req(2) !== 32'h2000) begin
      nerr++;
      $display("FAIL coin_reqs: %h %h %h want 0 4 2000",
               get_req(0), get_req(1), get_req(2));
    end
    nchk++;
    if (get_ppc(0) !== 32'h2000 || get_pdat(0) !== ~32'h2000) begin
      nerr++;
      $display("FAIL coin_pop: pc %h data %h want 2000/%h",
               get_ppc(0), get_pdat(0), ~32'h2000);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8;
    exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    mark();
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    rsp_en        = 1'b1;
    nchk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFF8) begin
      nerr++;
      $display("FAIL wrap_start: valid %b addr %h want 1/fffffff8",
               mem_req_valid, mem_req_addr);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (get_req(i) !== exp_a[i] || get_ppc(i) !== exp_a[i]
          || get_pdat(i) !== ~exp_a[i]) begin
        nerr++;
        $display("FAIL wrap%0d: req %h pc %h data %h want %h",
                 i, get_req(i), get_ppc(i), get_pdat(i), exp_a[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mark();
    mem_req_ready = 1'b1;
    rsp_en        = 1'b1;
    repeat (3) @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    nchk++;
    if (occupancy !== 3'd3) begin
      nerr++;
      $display("FAIL arst_pre: occ %0d want 3", occupancy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0
        || occupancy !== 3'd0) begin
      nerr++;
      $display("FAIL arst_ctl: req %b valid %b occ %0d want 0/0/0",
               mem_req_valid, instr_valid, occupancy);
    end
    nchk++;
    if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin
      nerr++;
      $display("FAIL arst_head: data %h pc %h want 0/0",
               instr_data, instr_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    repeat (5) @(negedge clk);
    nchk++;
    if (get_req(0) !== 32'h0 || get_ppc(0) !== 32'h0
        || get_pdat(0) !== ~32'h0) begin
      nerr++;
      $display("FAIL arst_refetch: req %h pc %h data %h want 0",
               get_req(0), get_ppc(0), get_pdat(0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_coincident();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
